// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the PWM ramp controller: ramp sequencer state
// encoding and the default duty width / step pacing used by pwm_core and
// pwm_ramp_ctrl.
package pwm_pkg;

  localparam int DUTY_W_DEF       = 4;
  localparam int STEP_PERIODS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/pwm_core.sv
// pwm_core
// Free-running PWM period counter with duty comparator and registered output.
// Ports:
//   clk      - sole clock, rising edge
//   rst      - synchronous active-high reset
//   en       - run enable; low freezes the counter and forces pwm_o low
//   duty     - duty compare value, sampled every cycle
//   pwm_o    - registered PWM output, one cycle behind the compare
//   boundary - high in the last cycle of a period (cnt at max while enabled)
module pwm_core
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_o,
  output logic              boundary
);

  localparam logic [DUTY_W-1:0] CNT_MAX = '1;

  logic [DUTY_W-1:0] cnt;

  // Counter wraps naturally at 2^DUTY_W; it holds in place while en is low
  // so a frozen ramp resumes with its period phase intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      pwm_o <= 1'b0;
    end else begin
      if (en) cnt <= cnt + 1'b1;
      pwm_o <= en && (cnt < duty);
    end
  end

  assign boundary = en && (cnt == CNT_MAX);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// PWM generator whose applied duty ramps one LSB at a time toward an accepted
// target, one step every STEP_PERIODS full PWM periods. Duty only changes on a
// period boundary so the waveform never glitches mid-period.
// Build option: define PWM_RAMP_DONE_EN to enable the done_o completion pulse;
// without it done_o is tied low.
// Ports:
//   clk       - sole clock, rising edge
//   rst       - synchronous active-high reset
//   en        - run enable; low freezes sequencer, forces pwm_o low
//   tgt_valid - new target duty offered
//   tgt_data  - target duty value
//   tgt_ready - target can be accepted this cycle
//   pwm_o     - registered PWM waveform
//   duty_o    - currently applied duty
//   busy_o    - high while ramping
//   done_o    - one-cycle pulse when the target is reached
//
// state | meaning
// IDLE  | duty at target, accepting new targets
// UP    | stepping duty up toward tgt_q
// DOWN  | stepping duty down toward tgt_q
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter int STEP_PERIODS = STEP_PERIODS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tgt_valid,
  input  logic [DUTY_W-1:0] tgt_data,
  output logic              tgt_ready,
  output logic              pwm_o,
  output logic [DUTY_W-1:0] duty_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [7:0] STEP_LAST = 8'(STEP_PERIODS - 1);

  ramp_state_t       state, state_nxt;
  logic [DUTY_W-1:0] duty_cur;
  logic [DUTY_W-1:0] tgt_q;
  logic [DUTY_W-1:0] duty_step;
  logic [7:0]        step;
  logic              boundary;
  logic              accept;
  logic              step_done;
  logic              ramp_end;

  pwm_core #(.DUTY_W(DUTY_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .duty     (duty_cur),
    .pwm_o    (pwm_o),
    .boundary (boundary)
  );

  assign accept    = tgt_valid && tgt_ready;
  assign step_done = boundary && (step == STEP_LAST) && (state != IDLE);
  assign duty_step = (state == UP) ? duty_cur + 1'b1 : duty_cur - 1'b1;
  // UP/DOWN are only entered with tgt_q strictly beyond duty_cur, so stopping
  // on equality also keeps duty_cur from overshooting or wrapping.
  assign ramp_end  = step_done && (duty_step == tgt_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (tgt_data > duty_cur)      state_nxt = UP;
          else if (tgt_data < duty_cur) state_nxt = DOWN;
        end
      end
      UP, DOWN: if (ramp_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tgt_ready = (state == IDLE) && en && !rst;
    busy_o    = (state != IDLE);
    duty_o    = duty_cur;
  end

  // Step counter counts completed periods; it is zero whenever the FSM is
  // idle because a ramp can only finish on a step completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_cur <= '0;
      tgt_q    <= '0;
      step     <= '0;
    end else begin
      if (accept) begin
        tgt_q <= tgt_data;
        step  <= '0;
      end
      if ((state != IDLE) && boundary) begin
        if (step == STEP_LAST) begin
          step     <= '0;
          duty_cur <= duty_step;
        end else begin
          step <= step + 8'd1;
        end
      end
    end
  end

`ifdef PWM_RAMP_DONE_EN
  always_ff @(posedge clk) begin
    if (rst) done_o <= 1'b0;
    else     done_o <= ramp_end || (accept && (tgt_data == duty_cur));
  end
`else
  assign done_o = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl
// Directed bench for pwm_ramp_ctrl (DUTY_W=4, STEP_PERIODS=4). A table of
// {cycle, inputs to drive, expected outputs} records is applied in order;
// cycle numbers count clock edges after the last reset edge. Hand-written
// sequences cover duty-0 / max-duty waveforms and the done pulse total.
module tb_pwm_ramp_ctrl;

`ifdef PWM_RAMP_DONE_EN
  localparam logic DONE_ON = 1'b1;
`else
  localparam logic DONE_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic       tgt_valid;
  logic [3:0] tgt_data;
  logic       tgt_ready;
  logic       pwm_o;
  logic [3:0] duty_o;
  logic       busy_o;
  logic       done_o;

  pwm_ramp_ctrl #(.DUTY_W(4), .STEP_PERIODS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_ready (tgt_ready),
    .pwm_o     (pwm_o),
    .duty_o    (duty_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         phase;
    int         cyc;
    logic       rst, en, vld;
    logic [3:0] data;
    logic       e_ready, e_busy;
    logic [3:0] e_duty;
    logic       e_done;
    int         e_pwm;   // -1: not checked
  } vec_t;

  vec_t vq[$];
  int   cyc;
  int   n_vec;
  int   n_err;
  int   done_cnt;

  always @(negedge clk) if (done_o === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic add(input int ph, input int c, input logic r, input logic e,
                     input logic v, input logic [3:0] d, input logic er,
                     input logic eb, input logic [3:0] ed, input logic edn,
                     input int ep);
    vec_t t;
    t.phase = ph; t.cyc = c; t.rst = r; t.en = e; t.vld = v; t.data = d;
    t.e_ready = er; t.e_busy = eb; t.e_duty = ed; t.e_done = edn; t.e_pwm = ep;
    vq.push_back(t);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; tgt_valid = 1'b0; tgt_data = '0;
    tick();
    tick();
    chk("rst_pwm", pwm_o, 0);
    chk("rst_duty", duty_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ready", tgt_ready, 0);
    rst = 1'b0;
    cyc = 0;
    #1;
    chk("rst_release_ready", tgt_ready, 1);
  endtask

  task automatic step_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at cycle %0d: got running expected finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    int n;
    rst = 1'b1; en = 1'b0; tgt_valid = 1'b0; tgt_data = '0;
    n_vec = 0; n_err = 0; done_cnt = 0; cyc = 0;

    // phase 1: ramp up 0->3, ramp down 3->1 with a held offer, en freeze, equal target
    //   ph cyc  rst en vld data  rdy busy duty done pwm
    add(1,   0, 0, 1, 1, 3,    1, 0, 0, 0,        0);
    add(1,   1, 0, 1, 0, 0,    0, 1, 0, 0,        0);
    add(1,  63, 0, 1, 0, 0,    0, 1, 0, 0,       -1);
    add(1,  64, 0, 1, 0, 0,    0, 1, 1, 0,        0);
    add(1,  65, 0, 1, 0, 0,    0, 1, 1, 0,        1);
    add(1,  66, 0, 1, 0, 0,    0, 1, 1, 0,        0);
    add(1, 127, 0, 1, 0, 0,    0, 1, 1, 0,       -1);
    add(1, 128, 0, 1, 0, 0,    0, 1, 2, 0,       -1);
    add(1, 191, 0, 1, 0, 0,    0, 1, 2, 0,       -1);
    add(1, 192, 0, 1, 1, 1,    1, 0, 3, DONE_ON, -1);
    add(1, 193, 0, 1, 1, 2,    0, 1, 3, 0,        1);
    add(1, 195, 0, 1, 1, 2,    0, 1, 3, 0,        1);
    add(1, 196, 0, 1, 1, 2,    0, 1, 3, 0,        0);
    add(1, 255, 0, 1, 1, 2,    0, 1, 3, 0,       -1);
    add(1, 256, 0, 1, 1, 2,    0, 1, 2, 0,       -1);
    add(1, 319, 0, 1, 1, 2,    0, 1, 2, 0,       -1);
    add(1, 320, 0, 1, 1, 2,    1, 0, 1, DONE_ON, -1);
    add(1, 321, 0, 1, 0, 0,    0, 1, 1, 0,       -1);
    add(1, 337, 0, 1, 0, 0,    0, 1, 1, 0,        1);
    add(1, 340, 0, 0, 0, 0,    0, 1, 1, 0,        0);
    add(1, 341, 0, 0, 0, 0,    0, 1, 1, 0,        0);
    add(1, 359, 0, 0, 0, 0,    0, 1, 1, 0,        0);
    add(1, 360, 0, 1, 0, 0,    0, 1, 1, 0,        0);
    add(1, 372, 0, 1, 0, 0,    0, 1, 1, 0,        0);
    add(1, 373, 0, 1, 0, 0,    0, 1, 1, 0,        1);
    add(1, 403, 0, 1, 0, 0,    0, 1, 1, 0,       -1);
    add(1, 404, 0, 1, 1, 5,    1, 0, 2, DONE_ON, -1);
    add(1, 405, 0, 1, 0, 0,    0, 1, 2, 0,       -1);
    add(1, 467, 0, 1, 0, 0,    0, 1, 2, 0,       -1);
    add(1, 468, 0, 1, 0, 0,    0, 1, 3, 0,       -1);
    add(1, 531, 0, 1, 0, 0,    0, 1, 3, 0,       -1);
    add(1, 532, 0, 1, 0, 0,    0, 1, 4, 0,       -1);
    add(1, 595, 0, 1, 0, 0,    0, 1, 4, 0,       -1);
    add(1, 596, 0, 1, 1, 5,    1, 0, 5, DONE_ON, -1);
    add(1, 597, 0, 1, 0, 0,    1, 0, 5, DONE_ON, -1);
    add(1, 598, 0, 1, 0, 0,    1, 0, 5, 0,       -1);
    // phase 2: en low in idle, ramp toward 4, reset at duty 2 (offer during rst ignored)
    add(2,   0, 0, 0, 0, 0,    1, 0, 0, 0,        0);
    add(2,   1, 0, 1, 1, 4,    0, 0, 0, 0,        0);
    add(2,   2, 0, 1, 0, 0,    0, 1, 0, 0,       -1);
    add(2,  64, 0, 1, 0, 0,    0, 1, 0, 0,       -1);
    add(2,  65, 0, 1, 0, 0,    0, 1, 1, 0,       -1);
    add(2, 128, 0, 1, 0, 0,    0, 1, 1, 0,       -1);
    add(2, 129, 1, 1, 1, 7,    0, 1, 2, 0,       -1);
    add(2, 130, 0, 1, 0, 0,    0, 0, 0, 0,        0);
    add(2, 131, 0, 1, 0, 0,    1, 0, 0, 0,        0);
    add(2, 260, 0, 1, 0, 0,    1, 0, 0, 0,        0);

    for (int p = 1; p <= 2; p++) begin
      do_reset();
      for (int i = 0; i < vq.size(); i++) begin
        if (vq[i].phase == p) begin
          step_to(vq[i].cyc);
          chk("ready", tgt_ready, vq[i].e_ready);
          chk("busy", busy_o, vq[i].e_busy);
          chk("duty", duty_o, vq[i].e_duty);
          chk("done", done_o, vq[i].e_done);
          if (vq[i].e_pwm >= 0) chk("pwm", pwm_o, vq[i].e_pwm);
          rst = vq[i].rst; en = vq[i].en;
          tgt_valid = vq[i].vld; tgt_data = vq[i].data;
        end
      end
    end

    // duty 0: constant low over a full period
    hi = 0;
    repeat (16) begin tick(); hi += int'(pwm_o); end
    chk("duty0_pwm_high_count", hi, 0);

    // ramp to max duty; must settle at 15 without wrapping
    tgt_valid = 1'b1; tgt_data = 4'd15;
    tick();
    tgt_valid = 1'b0;
    chk("max_accept_busy", busy_o, 1);
    n = 0;
    while (busy_o && n < 1200) begin tick(); n++; end
    chk("max_ramp_finished", busy_o, 0);
    chk("max_duty", duty_o, 15);
    hi = 0;
    repeat (16) begin tick(); hi += int'(pwm_o); end
    chk("max_pwm_high_count", hi, 15);
    repeat (100) tick();
    chk("max_duty_hold", duty_o, 15);
    chk("max_busy_hold", busy_o, 0);

    chk("done_pulse_total", done_cnt, DONE_ON ? 6 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
